// File: rtl/pipelined_data_memory_if.sv
// Request/response bundle between the load/store unit (master) and pipelined_data_memory (slave).
interface pipelined_data_memory_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wd;
  logic [1:0]  i_mask_type;
  logic        i_ext_type;
  logic        o_rsp_valid;
  logic        o_rsp_we;
  logic [31:0] o_rd;
  logic        o_rsp_err;

  modport master (
    output i_req_valid, i_we, i_addr, i_wd, i_mask_type, i_ext_type,
    input  o_req_ready, o_rsp_valid, o_rsp_we, o_rd, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_we, i_addr, i_wd, i_mask_type, i_ext_type,
    output o_req_ready, o_rsp_valid, o_rsp_we, o_rd, o_rsp_err
  );
endinterface

// File: rtl/pipelined_data_memory.sv
// Pipelined byte/half/word data memory with valid/ready requests, 1- or 2-cycle read latency and
// self-clearing init after reset. Define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses as errors.
module pipelined_data_memory #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input logic                     i_clk,
  input logic                     i_rst,
  pipelined_data_memory_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] mask, input logic zext);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (mask)
      2'b00:   extend_load = zext ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extend_load = zext ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
      default: extend_load = w;
    endcase
  endfunction

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic          accept, misal, req_err;
  logic [AW-1:0] widx;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [31:0]   lane_wd;
  logic          unused_addr;

  assign bus.o_req_ready = (state_q == ST_READY);
  assign accept          = bus.i_req_valid && bus.o_req_ready && !i_rst;
  assign widx            = bus.i_addr[2 +: AW];
  assign unused_addr     = ^bus.i_addr[31:2+AW];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misal = ((bus.i_mask_type == 2'b01) && bus.i_addr[0]) ||
                 ((bus.i_mask_type == 2'b10) && (bus.i_addr[1:0] != 2'b00));
  assign off   = bus.i_addr[1:0];
`else
  // Misaligned halves/words are silently realigned down to their natural boundary.
  assign misal = 1'b0;
  assign off   = (bus.i_mask_type == 2'b01) ? {bus.i_addr[1], 1'b0} :
                 (bus.i_mask_type == 2'b10) ? 2'b00 : bus.i_addr[1:0];
`endif
  assign req_err = (bus.i_mask_type == 2'b11) || misal;

  always_comb begin
    be      = 4'b0000;
    lane_wd = bus.i_wd;
    case (bus.i_mask_type)
      2'b00:   begin be = 4'b0001 << off;                   lane_wd = {4{bus.i_wd[7:0]}};  end
      2'b01:   begin be = off[1] ? 4'b1100 : 4'b0011;       lane_wd = {2{bus.i_wd[15:0]}}; end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (req_err) be = 4'b0000;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(DEPTH_WORDS - 1)) state_d = ST_READY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single write port shared by the init sweep and accepted stores.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (state_q == ST_INIT)) begin
      mem_q[cnt_q] <= '0;
    end else if (accept && bus.i_we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_q[widx][8*b +: 8] <= lane_wd[8*b +: 8];
    end
  end

  // ---- stage p0: synchronous RAM read and request attributes ----
  logic        vld_p0_q, we_p0_q, err_p0_q, zext_p0_q;
  logic [1:0]  off_p0_q, mask_p0_q;
  logic [31:0] rdata_p0_q;
  logic [31:0] rd_p0;

  always_ff @(posedge i_clk) begin
    if (i_rst) vld_p0_q <= 1'b0;
    else       vld_p0_q <= accept;
    if (accept) begin
      rdata_p0_q <= mem_q[widx];
      off_p0_q   <= off;
      mask_p0_q  <= bus.i_mask_type;
      zext_p0_q  <= bus.i_ext_type;
      we_p0_q    <= bus.i_we;
      err_p0_q   <= req_err;
    end
  end

  assign rd_p0 = (vld_p0_q && !we_p0_q && !err_p0_q) ?
                 extend_load(rdata_p0_q, off_p0_q, mask_p0_q, zext_p0_q) : '0;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      // ---- stage p1: output register ----
      logic        vld_p1_q, we_p1_q, err_p1_q;
      logic [31:0] rd_p1_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) vld_p1_q <= 1'b0;
        else       vld_p1_q <= vld_p0_q;
        rd_p1_q  <= rd_p0;
        we_p1_q  <= we_p0_q;
        err_p1_q <= err_p0_q;
      end

      assign bus.o_rsp_valid = vld_p1_q;
      assign bus.o_rsp_we    = vld_p1_q && we_p1_q;
      assign bus.o_rsp_err   = vld_p1_q && err_p1_q;
      assign bus.o_rd        = vld_p1_q ? rd_p1_q : '0;
    end else begin : g_lat1
      assign bus.o_rsp_valid = vld_p0_q;
      assign bus.o_rsp_we    = vld_p0_q && we_p0_q;
      assign bus.o_rsp_err   = vld_p0_q && err_p0_q;
      assign bus.o_rd        = rd_p0;
    end
  endgenerate
endmodule

// File: tb/tb_pipelined_data_memory.sv
// Drives one request stream into a latency-1 and a latency-2 instance and scoreboards both.
module tb_pipelined_data_memory;
  localparam int DEPTH = 64;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  mask;
    logic        ext;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        we;
    int          issue;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  sb_t  q1[$];
  sb_t  q2[$];
  vec_t vecs[$];

  pipelined_data_memory_if d1();
  pipelined_data_memory_if d2();

  pipelined_data_memory #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(1)) u_lat1 (.i_clk(clk), .i_rst(rst), .bus(d1));
  pipelined_data_memory #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(2)) u_lat2 (.i_clk(clk), .i_rst(rst), .bus(d2));

  assign d2.i_req_valid = d1.i_req_valid;
  assign d2.i_we        = d1.i_we;
  assign d2.i_addr      = d1.i_addr;
  assign d2.i_wd        = d1.i_wd;
  assign d2.i_mask_type = d1.i_mask_type;
  assign d2.i_ext_type  = d1.i_ext_type;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (d1.o_rsp_valid === 1'b1) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL lat1_unexpected_rsp: got rsp rd=%h, required no response", d1.o_rd);
      end else begin
        e = q1.pop_front();
        chk("lat1_rd", d1.o_rd, e.rd);
        chk("lat1_err", 32'(d1.o_rsp_err), 32'(e.err));
        chk("lat1_we", 32'(d1.o_rsp_we), 32'(e.we));
        chk("lat1_latency", 32'(cyc - e.issue), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    sb_t e;
    if (d2.o_rsp_valid === 1'b1) begin
      if (q2.size() == 0) begin
        n_chk++;
        $display("FAIL lat2_unexpected_rsp: got rsp rd=%h, required no response", d2.o_rd);
      end else begin
        e = q2.pop_front();
        chk("lat2_rd", d2.o_rd, e.rd);
        chk("lat2_err", 32'(d2.o_rsp_err), 32'(e.err));
        chk("lat2_we", 32'(d2.o_rsp_we), 32'(e.we));
        chk("lat2_latency", 32'(cyc - e.issue), 32'd1);
      end
    end
  end

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [1:0] mask, input logic ext,
                              input logic [31:0] rd, input logic err);
    vec_t v;
    v.we = we; v.addr = addr; v.wd = wd; v.mask = mask; v.ext = ext;
    v.exp_rd = rd; v.exp_err = err;
    return v;
  endfunction

  task automatic issue(input vec_t v, input bit p1, input bit p2);
    sb_t e;
    d1.i_req_valid = 1'b1;
    d1.i_we        = v.we;
    d1.i_addr      = v.addr;
    d1.i_wd        = v.wd;
    d1.i_mask_type = v.mask;
    d1.i_ext_type  = v.ext;
    chk("ready_at_issue", 32'(d1.o_req_ready), 32'd1);
    @(posedge clk); #1;
    e.rd = v.exp_rd; e.err = v.exp_err; e.we = v.we; e.issue = cyc;
    if (p1) q1.push_back(e);
    if (p2) q2.push_back(e);
  endtask

  task automatic count_init(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (d1.o_req_ready !== 1'b1 && n < 4 * DEPTH);
    chk(nm, 32'(n), 32'(DEPTH));
    chk({nm, "_lat2_ready"}, 32'(d2.o_req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] w1000;
    w1000 = TRAP ? 32'h92B4B478 : 32'h92B4AAAA;
    vecs.push_back(mk(1, 32'd1000, 32'h12345678, 2'b10, 0, 32'h0,        0));
    vecs.push_back(mk(0, 32'd1000, 32'h0,        2'b00, 0, 32'h00000078, 0));
    vecs.push_back(mk(0, 32'd1003, 32'h0,        2'b00, 0, 32'h00000012, 0));
    vecs.push_back(mk(0, 32'd1000, 32'h0,        2'b10, 0, 32'h12345678, 0));
    vecs.push_back(mk(1, 32'd1002, 32'h000092B4, 2'b01, 0, 32'h0,        0));
    vecs.push_back(mk(0, 32'd1002, 32'h0,        2'b01, 0, 32'hFFFF92B4, 0));
    vecs.push_back(mk(0, 32'd1002, 32'h0,        2'b01, 1, 32'h000092B4, 0));
    vecs.push_back(mk(0, 32'd1000, 32'h0,        2'b10, 0, 32'h92B45678, 0));
    vecs.push_back(mk(1, 32'd1001, 32'h000000B4, 2'b00, 0, 32'h0,        0));
    vecs.push_back(mk(0, 32'd1001, 32'h0,        2'b00, 0, 32'hFFFFFFB4, 0));
    vecs.push_back(mk(0, 32'd1000, 32'h0,        2'b10, 0, 32'h92B4B478, 0));
    vecs.push_back(mk(1, 32'd1001, 32'h0000AAAA, 2'b01, 0, 32'h0,        TRAP));
    vecs.push_back(mk(0, 32'd1000, 32'h0,        2'b10, 0, w1000,        0));
    vecs.push_back(mk(1, 32'd1000, 32'hFFFFFFFF, 2'b11, 0, 32'h0,        1));
    vecs.push_back(mk(0, 32'd1000, 32'h0,        2'b10, 0, w1000,        0));
    vecs.push_back(mk(0, 32'd1000, 32'h0,        2'b11, 1, 32'h0,        1));
    vecs.push_back(mk(0, 32'd1000, 32'h0,        2'b00, 1, TRAP ? 32'h78 : 32'hAA, 0));
    vecs.push_back(mk(0, 32'd1002, 32'h0,        2'b10, 0, TRAP ? 32'h0 : w1000, TRAP));
    vecs.push_back(mk(0, 32'd1000 + 32'(4 * DEPTH), 32'h0, 2'b10, 0, w1000, 0));
    vecs.push_back(mk(1, 32'd1004, 32'h000000FF, 2'b10, 0, 32'h0,        0));
    vecs.push_back(mk(0, 32'd1004, 32'h0,        2'b00, 0, 32'hFFFFFFFF, 0));
    vecs.push_back(mk(0, 32'd1004, 32'h0,        2'b00, 1, 32'h000000FF, 0));
    vecs.push_back(mk(1, 32'd1005, 32'hFFFFFF5A, 2'b00, 0, 32'h0,        0));
    vecs.push_back(mk(0, 32'd1004, 32'h0,        2'b10, 0, 32'h00005AFF, 0));

    d1.i_req_valid = 1'b0; d1.i_we = 1'b0; d1.i_addr = '0; d1.i_wd = '0;
    d1.i_mask_type = 2'b10; d1.i_ext_type = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(d1.o_req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(d1.o_rsp_valid), 32'd0);
    chk("rst_rsp_we", 32'(d1.o_rsp_we), 32'd0);
    chk("rst_rd", d1.o_rd, 32'd0);
    chk("rst_err", 32'(d1.o_rsp_err), 32'd0);
    chk("rst_lat2_rsp_valid", 32'(d2.o_rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_init("init_len");

    issue(mk(1, 32'd1000, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0), 1, 1);
    d1.i_req_valid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Load in flight when reset hits: only the latency-1 response can escape.
    issue(mk(0, 32'd1000, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0), 1, 0);
    d1.i_req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (DEPTH / 2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    count_init("init_len_after_midreset");

    issue(mk(0, 32'd1000, 32'h0, 2'b10, 0, 32'h0, 0), 1, 1);
    for (int i = 0; i < vecs.size(); i++) issue(vecs[i], 1, 1);
    d1.i_req_valid = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("lat1_pending_at_end", 32'(q1.size()), 32'd0);
    chk("lat2_pending_at_end", 32'(q2.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipelined_data_memory.md
# pipelined_data_memory

Parametrised, pipelined data memory for the RV core load/store unit. It succeeds the single-cycle byte/halfword/word data memory with three additions: a valid/ready request handshake, a configurable read latency, and a self-clearing init sequence after reset. Misaligned and reserved-size accesses are optionally detected. It sits between the MEM pipeline stage and the core's local data RAM.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two, at least 16.
- `READ_LATENCY`, default 1: cycles from request acceptance to response; legal values 1 or 2.
- `i_clk`  in  1: clock; all state updates on the rising edge.
- `i_rst`  in  1: reset, synchronous, active-high.
- `i_req_valid`  in  1: request present.
- `o_req_ready`  out  1: block can accept a request this cycle.
- `i_we`  in  1: 1 = store, 0 = load.
- `i_addr`  in  32: byte address.
- `i_wd`  in  32: store data, LSB-aligned (byte in [7:0], half in [15:0]).
- `i_mask_type`  in  2: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- `i_ext_type`  in  1: loads only; 0 = sign-extend, 1 = zero-extend.
- `o_rsp_valid`  out  1: response present, one-cycle pulse per accepted request.
- `o_rsp_we`  out  1: echoes `i_we` of the responding request.
- `o_rd`  out  32: extended load data; 0 for stores and errored requests.
- `o_rsp_err`  out  1: request was misaligned or reserved and had no effect.

## Operation
- Word index: `i_addr[2 +: log2(DEPTH_WORDS)]`. Upper bits are ignored, so addresses alias modulo `4*DEPTH_WORDS`.
- A request is accepted when `i_req_valid && o_req_ready`. Up to one request is accepted per cycle, with no bubbles.
- Stores: byte enables are derived from `i_mask_type` and `i_addr[1:0]`.
  - Byte store: the lane selected by `addr[1:0]` gets `i_wd[7:0]`.
  - Halfword store: the half selected by `addr[1]` gets `i_wd[15:0]`.
  - Word store: all four lanes are written.
  - Lanes that are not enabled are unchanged.
- Loads: the selected byte or half is shifted to bit 0, then sign- or zero-extended per `i_ext_type`. Word loads ignore `i_ext_type`.
- Reserved `i_mask_type` = 11: no write, `o_rd` = 0, `o_rsp_err` = 1. This is always active, independent of the macro.
- Store followed by a load to the same word on the next cycle: the load returns the new data. The memory is written before the following read samples it, so no forwarding is needed.
- FSM states:
  - INIT: entered on reset. A counter walks 0..DEPTH_WORDS-1 and writes 0 to each word, one per cycle. `o_req_ready` = 0.
  - READY: entered after the last init write. `o_req_ready` = 1 permanently.
- Reset asserted mid-INIT or mid-READY: return to INIT and restart the counter at 0. In-flight responses are discarded; no `o_rsp_valid` is produced for them.

## Timing
- Reset values: `o_req_ready` = 0, `o_rsp_valid` = 0, `o_rsp_we` = 0, `o_rd` = 0, `o_rsp_err` = 0. The init counter resets to 0.
- INIT lasts exactly DEPTH_WORDS cycles after reset deassertion. `o_req_ready` rises on the edge that completes the last clear.
- `READ_LATENCY` = 1: a request accepted at edge N produces a response that is valid between edge N and edge N+1. It comes from the synchronous RAM read plus combinational extension.
- `READ_LATENCY` = 2: an extra output register is added, and the response appears one cycle later. Throughput is still one request per cycle.
- A store's memory update takes effect at the accepting edge. Its response follows with the same latency as a load.
- `o_rsp_valid` is a single-cycle pulse per request, and responses return in request order.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A halfword with `addr[0]` = 1, or a word with `addr[1:0]` ≠ 0, is a misaligned access.
  - A misaligned store does not write memory. A misaligned access returns `o_rd` = 0 and `o_rsp_err` = 1.
- `DMEM_MISALIGN_TRAP_EN` undefined:
  - The offending low address bits are forced to 0: halfword uses `addr[0]`=0, word uses `addr[1:0]`=0.
  - The access then proceeds normally with `o_rsp_err` = 0.

## Test plan
- Reset, then hold `i_req_valid`=0 → `o_req_ready` stays 0 for exactly DEPTH_WORDS cycles, then rises. A word load at 1000 returns 0x00000000. Asserting `i_rst` for one cycle mid-INIT restarts the full count.
- Word store 0x12345678 at 1000, then byte loads at 1000 and 1003 (sign) → 0x00000078 and 0x00000012. Word load at 1000 → 0x12345678.
- Half store 0x92B4 at 1002, then half load at 1002 signed → 0xFFFF92B4, unsigned → 0x000092B4. Word load at 1000 → 0x92B45678.
- Byte store 0xB4 at 1001, then byte load at 1001 signed → 0xFFFFFFB4. Word at 1000 → 0x92B4B478. Back-to-back store/load, one per cycle, with `READ_LATENCY` 1 and 2 → in-order responses at the stated latency.
- Half store 0xAAAA at 1001:
  - With `DMEM_MISALIGN_TRAP_EN` → `o_rsp_err`=1 and memory unchanged.
  - Without it → writes 1000 and the word at 1000 reads 0x92B4AAAA.
- Request with `i_mask_type`=11 and `i_we`=1, wd 0xFFFFFFFF, at 1000 → `o_rsp_err`=1, `o_rd`=0, memory unchanged.
